// File: rtl/pc_pkg.sv
// Shared encodings for the fetch program-counter generator: redirect modes,
// FSM states, instruction length and target alignment helpers.
package pc_pkg;

  localparam logic [2:0] MODE_STALL  = 3'b000;
  localparam logic [2:0] MODE_INCR   = 3'b001;
  localparam logic [2:0] MODE_JALR   = 3'b010;
  localparam logic [2:0] MODE_BRANCH = 3'b011;
  localparam logic [2:0] MODE_TRAP   = 3'b100;
  localparam logic [2:0] MODE_RET    = 3'b101;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int ILEN = 4;

  // Low-bit masks cleared from JALR and trap-vector targets.
  localparam logic [1:0] JALR_CLR_MASK = 2'b01;
  localparam logic [1:0] TRAP_CLR_MASK = 2'b11;

  // A fetch target is rejected when it is not 4-byte aligned in bit 1.
  function automatic logic target_misaligned(input logic [1:0] lsbs);
    return lsbs[1];
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; pushing while full overwrites the oldest
// entry. Only instantiated when PC_RAS_EN is defined.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] stack_q [DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   top_idx;
  logic [PW:0]     count_q;

  assign top_idx = ptr_q - PW'(1);
  assign top     = stack_q[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PW'(1);
      if (!full) count_q <= count_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr_q   <= top_idx;
      count_q <= count_q - (PW+1)'(1);
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[ptr_q] <= push_addr;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BOOT/RUN/HALT sequencing, trap and branch redirects
// and misaligned-target rejection. Define PC_RAS_EN to add a return-address stack.
//
// state | meaning
// BOOT  | one cycle after reset, no valid PC yet
// RUN   | pc_o valid toward fetch, redirects and INCR applied
// HALT  | pc_o held and invalid; only TRAP or resume leave
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mode_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] tvec_i,
  input  logic            call_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            pc_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o,
  output logic            halted_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_d, bad_addr_d;
  logic            misalign_d;
  logic [XLEN-1:0] seq_pc, br_tgt, jalr_tgt, trap_tgt, redir_tgt;
  logic            is_redir, redir_bad, redir_ok;
  logic            ras_push, ras_pop, ras_use, ras_empty;
  logic [XLEN-1:0] ras_top;
  logic            unused_ras;

`ifdef PC_RAS_EN
  logic ras_full;

  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign unused_ras = ras_full;
`else
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_ras = ras_push ^ ras_pop ^ call_i;
`endif

  assign ras_use = (mode_i == MODE_RET) && !ras_empty;

  always_comb begin
    seq_pc    = pc_o + XLEN'(ILEN);
    br_tgt    = pc_o + imm_i;
    jalr_tgt  = (base_i + imm_i) & ~XLEN'(JALR_CLR_MASK);
    trap_tgt  = tvec_i & ~XLEN'(TRAP_CLR_MASK);
    is_redir  = mode_i inside {MODE_BRANCH, MODE_JALR, MODE_RET};
    redir_tgt = (mode_i == MODE_BRANCH) ? br_tgt : (ras_use ? ras_top : jalr_tgt);
    redir_bad = target_misaligned(redir_tgt[1:0]);
    redir_ok  = is_redir && !redir_bad;

    state_d    = state_q;
    pc_d       = pc_o;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_o;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (mode_i == MODE_TRAP) begin
          pc_d = trap_tgt;
        end else begin
          if (redir_ok) begin
            pc_d     = redir_tgt;
            ras_push = call_i && (mode_i != MODE_RET);
            ras_pop  = ras_use;
          end else if (is_redir) begin
            misalign_d = 1'b1;
            bad_addr_d = redir_tgt;
          end
          // A rejected redirect does not defer a pending halt.
          if (halt_i && !redir_ok) begin
            state_d = ST_HALT;
          end else if (!is_redir && mode_i == MODE_INCR && pc_ready_i) begin
            pc_d = seq_pc;
          end
        end
      end
      ST_HALT: begin
        if (mode_i == MODE_TRAP) begin
          pc_d    = trap_tgt;
          state_d = ST_RUN;
        end else if (resume_i && !halt_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_o       <= RESET_VEC;
      pc_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bad_addr_o <= '0;
      halted_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_o       <= pc_d;
      pc_valid_o <= (state_d == ST_RUN);
      misalign_o <= misalign_d;
      bad_addr_o <= bad_addr_d;
      halted_o   <= (state_d == ST_HALT);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then random traffic, checked
// against a flag/queue based reference model. Honours PC_RAS_EN like the RTL.
module tb_pc_gen;
  import pc_pkg::*;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode_i;
  logic [31:0] imm_i, base_i, tvec_i;
  logic        call_i, halt_i, resume_i, pc_ready_i;
  logic [31:0] pc_o, bad_addr_o;
  logic        pc_valid_o, misalign_o, halted_o;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .imm_i(imm_i), .base_i(base_i),
    .tvec_i(tvec_i), .call_i(call_i), .halt_i(halt_i), .resume_i(resume_i),
    .pc_ready_i(pc_ready_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .misalign_o(misalign_o), .bad_addr_o(bad_addr_o), .halted_o(halted_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic [31:0] bad;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: boot/halt flags plus a plain queue as the call stack.
  logic [31:0] m_pc, m_bad;
  bit          m_boot, m_halt, m_mis;
  logic [31:0] m_ras[$];

  task automatic model_step(input logic r, input logic [2:0] md, input logic [31:0] imm,
                            input logic [31:0] base, input logic [31:0] tvec,
                            input logic call, input logic halt, input logic resume,
                            input logic ready);
    logic [31:0] tgt;
    bit          from_stack;
    bit          is_jump;
    from_stack = 0;
    m_mis = 0;
    is_jump = (md == MODE_BRANCH) || (md == MODE_JALR) || (md == MODE_RET);
    if (r) begin
      m_pc = RV; m_boot = 1; m_halt = 0; m_bad = 0;
      m_ras.delete();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (md == MODE_TRAP) begin
        m_pc = {tvec[31:2], 2'b00};
        m_halt = 0;
      end else if (resume && !halt) begin
        m_halt = 0;
      end
    end else if (md == MODE_TRAP) begin
      m_pc = {tvec[31:2], 2'b00};
    end else if (is_jump) begin
      if (md == MODE_BRANCH) tgt = m_pc + imm;
      else tgt = (base + imm) & 32'hFFFF_FFFE;
`ifdef PC_RAS_EN
      if (md == MODE_RET && m_ras.size() > 0) begin
        tgt = m_ras[$];
        from_stack = 1;
      end
`endif
      if (tgt % 4 >= 2) begin
        m_mis = 1;
        m_bad = tgt;
        if (halt) m_halt = 1;
      end else begin
`ifdef PC_RAS_EN
        if (from_stack) void'(m_ras.pop_back());
        if (call && md != MODE_RET) begin
          m_ras.push_back(m_pc + 4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
`endif
        m_pc = tgt;
      end
    end else if (halt) begin
      m_halt = 1;
    end else if (md == MODE_INCR && ready) begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] md, input logic [31:0] imm,
                       input logic [31:0] base, input logic [31:0] tvec, input logic call,
                       input logic halt, input logic resume, input logic ready);
    exp_t e;
    rst = r; mode_i = md; imm_i = imm; base_i = base; tvec_i = tvec;
    call_i = call; halt_i = halt; resume_i = resume; pc_ready_i = ready;
    model_step(r, md, imm, base, tvec, call, halt, resume, ready);
    e.pc = m_pc; e.valid = !m_boot && !m_halt; e.mis = m_mis;
    e.bad = m_bad; e.halted = m_halt;
    exp_q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_o", pc_o, e.pc);
      check("pc_valid_o", {31'b0, pc_valid_o}, {31'b0, e.valid});
      check("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
      check("bad_addr_o", bad_addr_o, e.bad);
      check("halted_o", {31'b0, halted_o}, {31'b0, e.halted});
    end
  end

  initial begin
    logic [2:0]  md;
    logic [31:0] rnd_imm;
    int          sel;

    // reset, boot, counting
    drive(1, MODE_INCR, 0, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_INCR, 0, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_INCR, 0, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_INCR, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) drive(0, MODE_INCR, 0, 0, 0, 0, 0, 0, 0);
    drive(0, MODE_BRANCH, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
    // JALR aligned and misaligned
    drive(0, MODE_JALR, 32'h0FF, 32'h101, 0, 0, 0, 0, 1);
    drive(0, MODE_JALR, 32'h002, 32'h100, 0, 0, 0, 0, 1);
    drive(0, MODE_STALL, 0, 0, 0, 0, 0, 0, 1);
    // wrap-around
    drive(0, MODE_BRANCH, 32'hFFFF_FFFC - 32'h200, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_INCR, 0, 0, 0, 0, 0, 0, 1);
    // halt, both halt+resume, trap out of halt
    drive(0, MODE_STALL, 0, 0, 0, 0, 1, 0, 1);
    drive(0, MODE_INCR, 0, 0, 0, 0, 1, 1, 1);
    drive(0, MODE_BRANCH, 32'h40, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_TRAP, 0, 0, 32'h8000_0003, 0, 0, 0, 1);
    // halt coincident with branch, then reset during halt
    drive(0, MODE_BRANCH, 32'h10, 0, 0, 0, 1, 0, 1);
    drive(0, MODE_STALL, 0, 0, 0, 0, 1, 0, 1);
    drive(0, MODE_STALL, 0, 0, 0, 0, 0, 0, 1);
    drive(1, MODE_STALL, 0, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_STALL, 0, 0, 0, 0, 0, 0, 1);
    drive(0, MODE_STALL, 0, 0, 0, 0, 0, 1, 1);
    // five calls then five returns
    drive(0, MODE_TRAP, 0, 0, 32'h10, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) drive(0, MODE_BRANCH, 32'h10, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) drive(0, MODE_RET, 32'h0, 32'h100, 0, 0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: md = MODE_INCR;
        4:          md = MODE_STALL;
        5:          md = MODE_BRANCH;
        6:          md = MODE_JALR;
        7:          md = MODE_RET;
        8:          md = MODE_TRAP;
        default:    md = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
      endcase
      rnd_imm = $urandom & 32'h0000_FFFE;
      if ($urandom_range(0, 1) == 0) rnd_imm = -rnd_imm;
      drive($urandom_range(0, 63) == 0, md, rnd_imm, $urandom, $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
